// File: rtl/vector_packer.sv
// vector_packer: packs a scalar element stream into padded N-lane vectors with eof tagging
module vector_packer #(
  parameter int N = 16,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [1:0]                   in_eof,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        vector_out [N],
  output logic                         enqueue_out,
  output logic [1:0]                   eof_out,
  output logic [$clog2(N+1)-1:0]       lanes_valid,
  output logic [COUNT_WIDTH-1:0]       vec_count
);
  localparam int IW = $clog2(N);
  localparam int LW = $clog2(N+1);
  logic [DATA_WIDTH-1:0]  lane_q [N];
  logic [DATA_WIDTH-1:0]  lane_d [N];
  logic [DATA_WIDTH-1:0]  vec_q [N];
  logic [DATA_WIDTH-1:0]  vec_d [N];
  logic [IW-1:0]          idx_q, idx_d;
  logic                   enq_q, enq_d;
  logic [1:0]             eof_q, eof_d;
  logic [LW-1:0]          lv_q, lv_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   emit;
  logic [LW-1:0]          fill;
  always_comb begin
    emit  = in_valid ? (idx_q == IW'(N-1) || |in_eof || flush) : (flush && idx_q != '0);
    fill  = LW'(idx_q) + LW'(in_valid);
    for (int i = 0; i < N; i++) begin
      lane_d[i] = (in_valid && idx_q == IW'(i)) ? in_data : lane_q[i];
      vec_d[i]  = emit ? ((LW'(i) < fill) ? lane_d[i] : PAD_VALUE) : vec_q[i];
    end
    idx_d = emit ? '0 : in_valid ? idx_q + IW'(1) : idx_q;
    enq_d = emit;
    eof_d = emit ? (in_valid ? in_eof : 2'b00) : eof_q;
    lv_d  = emit ? fill : lv_q;
    cnt_d = cnt_q + COUNT_WIDTH'(emit);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '{default: '0};
      vec_q  <= '{default: '0};
      idx_q  <= '0;
      enq_q  <= 1'b0;
      eof_q  <= 2'b00;
      lv_q   <= '0;
      cnt_q  <= '0;
    end else begin
      lane_q <= lane_d;
      vec_q  <= vec_d;
      idx_q  <= idx_d;
      enq_q  <= enq_d;
      eof_q  <= eof_d;
      lv_q   <= lv_d;
      cnt_q  <= cnt_d;
    end
  end
  assign vector_out  = vec_q;
  assign enqueue_out = enq_q;
  assign eof_out     = eof_q;
  assign lanes_valid = lv_q;
  assign vec_count   = cnt_q;
endmodule

// File: tb/tb_vector_packer.sv
// tb_vector_packer: randomized and directed checks of vector_packer against a queue-based model
module tb_vector_packer;
  localparam int N = 16;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [DW-1:0] PAD = 32'hA5A5_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [1:0] in_eof = 2'b00;
  logic flush = 1'b0;
  logic [DW-1:0] vector_out [N];
  logic enqueue_out;
  logic [1:0] eof_out;
  logic [4:0] lanes_valid;
  logic [CW-1:0] vec_count;
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] pend [$];
  logic [DW-1:0] exp_vec [N];
  logic [1:0] exp_eof;
  int exp_lv;
  logic [CW-1:0] exp_cnt;
  bit last_emit;
  vector_packer #(.N(N), .DATA_WIDTH(DW), .PAD_VALUE(PAD), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_eof(in_eof),
    .flush(flush), .vector_out(vector_out), .enqueue_out(enqueue_out), .eof_out(eof_out),
    .lanes_valid(lanes_valid), .vec_count(vec_count)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [1:0] e, input logic f);
    int bad;
    in_valid = v; in_data = d; in_eof = e; flush = f;
    @(posedge clk); #1;
    if (v) pend.push_back(d);
    last_emit = v ? (pend.size() == N || e != 2'b00 || f) : (f && pend.size() > 0);
    if (last_emit) begin
      for (int i = 0; i < N; i++) exp_vec[i] = (i < pend.size()) ? pend[i] : PAD;
      exp_lv = pend.size();
      exp_eof = v ? e : 2'b00;
      exp_cnt = exp_cnt + 1'b1;
      pend.delete();
    end
    in_valid = 1'b0; in_eof = 2'b00; flush = 1'b0;
    n_checks++;
    if (enqueue_out !== last_emit) begin
      n_fail++; $display("FAIL enqueue_out: got %b required %b at %0t", enqueue_out, last_emit, $time);
    end
    n_checks++;
    if (vec_count !== exp_cnt) begin
      n_fail++; $display("FAIL vec_count: got %0d required %0d at %0t", vec_count, exp_cnt, $time);
    end
    n_checks++;
    if (eof_out !== exp_eof) begin
      n_fail++; $display("FAIL eof_out: got %b required %b at %0t", eof_out, exp_eof, $time);
    end
    n_checks++;
    if (lanes_valid !== 5'(exp_lv)) begin
      n_fail++; $display("FAIL lanes_valid: got %0d required %0d at %0t", lanes_valid, exp_lv, $time);
    end
    bad = -1;
    for (int i = N - 1; i >= 0; i--) if (vector_out[i] !== exp_vec[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++; $display("FAIL vector_out lane %0d: got %h required %h at %0t", bad, vector_out[bad], exp_vec[bad], $time);
    end
  endtask
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      in_valid = 1'($urandom); in_data = $urandom; in_eof = 2'($urandom); flush = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (enqueue_out !== 1'b0 || vec_count !== '0 || eof_out !== 2'b00 || lanes_valid !== '0) begin
        n_fail++;
        $display("FAIL reset outputs: got enq=%b cnt=%0d eof=%b lv=%0d required 0 0 00 0", enqueue_out, vec_count, eof_out, lanes_valid);
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (vector_out[i] !== '0) begin
          n_fail++; $display("FAIL reset vector_out lane %0d: got %h required 0", i, vector_out[i]);
        end
      end
    end
    reset = 1'b0; in_valid = 1'b0; in_eof = 2'b00; flush = 1'b0;
    pend.delete();
    for (int i = 0; i < N; i++) exp_vec[i] = '0;
    exp_eof = 2'b00; exp_lv = 0; exp_cnt = '0;
  endtask
  task automatic test_reset();
    do_reset(3);
  endtask
  task automatic test_full();
    for (int k = 1; k <= N; k++) begin
      step(1'b1, DW'(k), 2'b00, 1'b0);
      n_checks++;
      if (enqueue_out !== (k == N)) begin
        n_fail++; $display("FAIL full pulse timing: element %0d got enq=%b", k, enqueue_out);
      end
    end
    n_checks++;
    if (vector_out[0] !== 32'd1 || vector_out[15] !== 32'd16 || lanes_valid !== 5'd16 || vec_count !== 4'd1) begin
      n_fail++;
      $display("FAIL full vector: got l0=%0d l15=%0d lv=%0d cnt=%0d required 1 16 16 1", vector_out[0], vector_out[15], lanes_valid, vec_count);
    end
  endtask
  task automatic test_partial_eof();
    for (int k = 0; k < 5; k++) step(1'b1, DW'(10 + k), (k == 4) ? 2'b01 : 2'b00, 1'b0);
    n_checks++;
    if (!enqueue_out || lanes_valid !== 5'd5 || eof_out !== 2'b01 || vector_out[4] !== 32'd14 || vector_out[5] !== PAD) begin
      n_fail++;
      $display("FAIL partial eof: got enq=%b lv=%0d eof=%b l4=%0d l5=%h required 1 5 01 14 %h", enqueue_out, lanes_valid, eof_out, vector_out[4], vector_out[5], PAD);
    end
    for (int k = 0; k < N; k++) step(1'b1, $urandom, 2'b00, 1'b0);
  endtask
  task automatic test_flush();
    for (int k = 0; k < 3; k++) step(1'b1, $urandom, 2'b00, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, $urandom, 2'($urandom), 1'b0);
    step(1'b0, '0, 2'b00, 1'b1);
    n_checks++;
    if (!enqueue_out || lanes_valid !== 5'd3 || eof_out !== 2'b00) begin
      n_fail++; $display("FAIL flush: got enq=%b lv=%0d eof=%b required 1 3 00", enqueue_out, lanes_valid, eof_out);
    end
    step(1'b0, '0, 2'b00, 1'b1);
    n_checks++;
    if (enqueue_out !== 1'b0) begin
      n_fail++; $display("FAIL empty flush: got enq=%b required 0", enqueue_out);
    end
    step(1'b1, 32'h77, 2'b10, 1'b1);
    n_checks++;
    if (!enqueue_out || lanes_valid !== 5'd1 || eof_out !== 2'b10) begin
      n_fail++; $display("FAIL flush with valid: got enq=%b lv=%0d eof=%b required 1 1 10", enqueue_out, lanes_valid, eof_out);
    end
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++) begin
      step(1'b1, $urandom, 2'b11, 1'b0);
      n_checks++;
      if (!enqueue_out || lanes_valid !== 5'd1) begin
        n_fail++; $display("FAIL back to back %0d: got enq=%b lv=%0d required 1 1", k, enqueue_out, lanes_valid);
      end
    end
  endtask
  task automatic test_reset_midway();
    for (int k = 0; k < 7; k++) step(1'b1, $urandom, 2'b00, 1'b0);
    do_reset(2);
    for (int k = 0; k < N; k++) step(1'b1, DW'(100 + k), 2'b00, 1'b0);
    n_checks++;
    if (!enqueue_out || vector_out[0] !== 32'd100 || vector_out[15] !== 32'd115 || vec_count !== 4'd1) begin
      n_fail++;
      $display("FAIL reset midway: got enq=%b l0=%0d l15=%0d cnt=%0d required 1 100 115 1", enqueue_out, vector_out[0], vector_out[15], vec_count);
    end
  endtask
  task automatic test_wrap();
    do_reset(1);
    for (int k = 0; k < 17; k++) step(1'b1, $urandom, 2'b01, 1'b0);
    n_checks++;
    if (vec_count !== 4'd1) begin
      n_fail++; $display("FAIL count wrap: got %0d required 1", vec_count);
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 500; k++)
      step($urandom_range(0, 3) != 0, $urandom,
           ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           $urandom_range(0, 14) == 0);
  endtask
  initial begin
    test_reset();
    test_full();
    test_partial_eof();
    test_flush();
    test_back_to_back();
    test_reset_midway();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
